// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-index width, decryption FSM
// states, GF(2^8) helpers for InvMixColumns and the (row, col) byte mapping.
package aes_pkg;

    localparam int NR        = 10;
    localparam int KEY_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // LSB position of the byte at (row, col); byte 0 sits in [127:120]
    // and bytes run down each column first.
    function automatic int byte_lsb(input int row, input int col);
        return 120 - 8 * (row + 4 * col);
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational AES inverse S-box as a constant lookup table.
module inv_s_box (
    input  logic [7:0] value,
    output logic [7:0] result
);

    // Entry for input v lives at bits [2047-8v -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] msb;

    // Table lookup: select the byte for this input value.
    assign msb    = 11'd2047 - {value, 3'b000};
    assign result = INV_SBOX[msb -: 8];

endmodule

// File: rtl/inv_oneround_iter.sv
// Iterative AES-128 decryption: one inverse round per clock
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), round keys
// fetched by index from an external key store.
//
// Handshake: start is taken only in a cycle where ready=1; data_in and
// key_in are sampled on that edge. done is a one-cycle strobe with
// data_out valid; data_out then holds until the next block completes.
module inv_oneround_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         data_in,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [127:0]         key_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [127:0]         data_out
);

    fsm_state_t           fsm;
    logic [KEY_IDX_W-1:0] rnd;
    logic [127:0]         state_reg;
    logic [127:0]         shifted;
    logic [127:0]         subbed;
    logic [127:0]         round_out;
    logic [127:0]         mixed;

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[byte_lsb(0, c) +: 8];
            a1 = s[byte_lsb(1, c) +: 8];
            a2 = s[byte_lsb(2, c) +: 8];
            a3 = s[byte_lsb(3, c) +: 8];
            o[byte_lsb(0, c) +: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
            o[byte_lsb(1, c) +: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
            o[byte_lsb(2, c) +: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
            o[byte_lsb(3, c) +: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        end
        return o;
    endfunction

    // InvShiftRows is pure wiring: (r,c) takes the byte from (r,(c-r) mod 4).
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int DST = byte_lsb(r, c);
            localparam int SRC = byte_lsb(r, (c - r + 4) % 4);
            assign shifted[DST +: 8] = state_reg[SRC +: 8];
            inv_s_box u_inv_s_box (
                .value  (shifted[DST +: 8]),
                .result (subbed[DST +: 8])
            );
        end
    end

    assign round_out = subbed ^ key_in;
    assign mixed     = inv_mix_columns(round_out);

    // Key index depends only on FSM state and round counter, never on start.
    always_comb begin
        key_idx = KEY_IDX_W'(NR);
        if (fsm == RUN) key_idx = rnd;
    end

    // Control FSM, round datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
            data_out  <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= data_in ^ key_in;
                        rnd       <= KEY_IDX_W'(NR - 1);
                        fsm       <= RUN;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        fsm   <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (rnd != '0) begin
                        state_reg <= mixed;
                        rnd       <= rnd - 1'b1;
                    end else begin
                        data_out <= round_out;
                        fsm      <= DONE;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_oneround_iter.sv
// Bench for inv_oneround_iter: textbook AES decryption model, timeline model
// of the control outputs, one per-cycle compare process and directed plus
// random block stimulus.
module tb_inv_oneround_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic [3:0]   key_idx;
    logic [127:0] key_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] data_out;

    logic         key_sel;
    logic [127:0] rk_set [2][11];
    logic [7:0]   sbox_fwd [256];
    logic [7:0]   sbox_inv [256];

    int           tests = 0;
    int           fails = 0;
    logic         chk_en = 1'b0;
    logic [127:0] exp_q[$];
    int           phase = 0;
    logic [127:0] held_out = '0;

    inv_oneround_iter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .key_idx  (key_idx),
        .key_in   (key_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    // ---------------- clock / key store ----------------
    always #5 clk = ~clk;

    assign key_in = (key_idx <= 4'd10) ? rk_set[key_sel][key_idx] : '0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 0;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_fwd[a] = s;
            sbox_inv[s] = 8'(a);
        end
    endtask

    task automatic expand_key(input logic [127:0] key, input int set);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_fwd[tmp[31:24]], sbox_fwd[tmp[23:16]],
                       sbox_fwd[tmp[15:8]], sbox_fwd[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            rk_set[set][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int ks);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] rk, res;
        rk = rk_set[ks][10];
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8 * i -: 8] ^ rk[127 - 8 * i -: 8];
        for (int round = 9; round >= 0; round--) begin
            rk = rk_set[ks][round];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    u[r + 4 * c] = sbox_inv[s[r + 4 * ((c - r + 4) % 4)]];
            for (int i = 0; i < 16; i++) u[i] = u[i] ^ rk[127 - 8 * i -: 8];
            if (round != 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(u[4*c], 8'h0e) ^ gmul(u[4*c+1], 8'h0b) ^ gmul(u[4*c+2], 8'h0d) ^ gmul(u[4*c+3], 8'h09);
                    s[4*c+1] = gmul(u[4*c], 8'h09) ^ gmul(u[4*c+1], 8'h0e) ^ gmul(u[4*c+2], 8'h0b) ^ gmul(u[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(u[4*c], 8'h0d) ^ gmul(u[4*c+1], 8'h09) ^ gmul(u[4*c+2], 8'h0e) ^ gmul(u[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(u[4*c], 8'h0b) ^ gmul(u[4*c+1], 8'h0d) ^ gmul(u[4*c+2], 8'h09) ^ gmul(u[4*c+3], 8'h0e);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = u[i];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    // phase: 0 idle, 1..10 running (k-th cycle after accept), 11 done cycle.
    always @(negedge clk) begin
        if (phase == 11) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL exp_q: done cycle with no queued block at %0t", $time);
            end else begin
                held_out = exp_q.pop_front();
            end
        end
        if (chk_en) begin
            check("ready", 128'(ready), 128'(phase == 0 || phase == 11));
            check("busy", 128'(busy), 128'(phase >= 1 && phase <= 10));
            check("done", 128'(done), 128'(phase == 11));
            check("key_idx", 128'(key_idx), 128'((phase >= 1 && phase <= 10) ? 10 - phase : 10));
            check("data_out", data_out, held_out);
        end
        if (rst) begin
            phase    = 0;
            held_out = '0;
            exp_q.delete();
        end else if ((phase == 0 || phase == 11) && start) begin
            exp_q.push_back(model_decrypt(data_in, int'(key_sel)));
            phase = 1;
        end else if (phase >= 1 && phase <= 10) begin
            phase++;
        end else begin
            phase = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] ct, input logic ks);
        data_in = ct;
        key_sel = ks;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = rand128();
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles", c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [127:0] rk_rand, ct_rand;
        rst = 1'b1; start = 1'b0; data_in = '0; key_sel = 1'b0;
        build_sbox();
        expand_key(C1_KEY, 0);
        expand_key(B_KEY, 1);

        // Literal pins on the model itself.
        check("model_rk10_c1", rk_set[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_rk10_b", rk_set[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_pt_c1", model_decrypt(C1_CT, 0), C1_PT);
        check("model_pt_b", model_decrypt(B_CT, 1), B_PT);

        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // FIPS-197 C.1
        start_block(C1_CT, 1'b0);
        wait_done(1, lat);
        check("c1_latency", 128'(lat), 128'd11);
        check("c1_pt", data_out, C1_PT);

        // Back-to-back: App. B started in the DONE cycle.
        start_block(B_CT, 1'b1);
        wait_done(1, lat);
        check("b2b_latency", 128'(lat), 128'd11);
        check("b_pt", data_out, B_PT);

        // Hold with data_in toggling.
        for (int i = 0; i < 20; i++) begin
            data_in = rand128();
            tick();
        end
        check("hold_data_out", data_out, B_PT);
        check("hold_key_idx", 128'(key_idx), 128'd10);
        check("hold_busy", 128'(busy), 128'd0);

        // Start pulses during RUN cycles 3 and 9.
        start_block(C1_CT, 1'b0);
        repeat (2) tick();
        data_in = rand128(); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        data_in = rand128(); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, lat);
        check("busy_start_latency", 128'(lat), 128'd11);
        check("busy_start_pt", data_out, C1_PT);
        tick();

        // Reset at RUN cycle 5.
        start_block(C1_CT, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_data_out", data_out, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        repeat (15) tick();
        start_block(C1_CT, 1'b0);
        wait_done(1, lat);
        check("post_rst_latency", 128'(lat), 128'd11);
        check("post_rst_pt", data_out, C1_PT);

        // Random keys and ciphertexts, random gaps or back-to-back.
        for (int i = 0; i < 6; i++) begin
            rk_rand = rand128();
            ct_rand = rand128();
            expand_key(rk_rand, i % 2);
            start_block(ct_rand, 1'(i % 2));
            wait_done(1, lat);
            check("rand_latency", 128'(lat), 128'd11);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (3) tick();

        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
